fir_input_buf: RTL and testbench

- Banked sample buffer that sits directly downstream of the FIR input-buffer address generator (bank/row generator) and consumes its bank and row outputs.
- Accepts input samples over a valid/ready handshake and writes each one into a 4-bank RAM at the generator's current (bank, row).
- Pulses the generator's enable for each accepted sample, and owns the generator's mode and reset.
- Streams stored rows out, one bank per word, to the FIR datapath over a valid/ready handshake.

---
 rtl/fir_input_buf_if.sv | 21 ++
 rtl/fir_input_buf.sv | 121 ++++++++++++
 tb/tb_fir_input_buf.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_input_buf_if.sv
// Stream handshakes of the FIR input buffer: samples in, banked words out.
interface fir_input_buf_if #(parameter int DW = 16);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_bank;
  logic          out_last;
  logic          out_ready;

  // master feeds samples and drains words; slave is the buffer itself
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_bank, out_last
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_bank, out_last
  );
endinterface

// File: rtl/fir_input_buf.sv
// Four-bank FIR sample buffer: writes at the address generator's (bank,row),
// streams complete rows out one bank per word.
module fir_input_buf #(
  parameter int DW = 16,
  parameter int AW = 10,
  parameter int FW = AW + 3
) (
  input  logic           clk,
  input  logic           r,
  input  logic           mode,
  fir_input_buf_if.slave strm,
  output logic           ag_mode,
  output logic           ag_en,
  output logic           ag_r,
  input  logic [1:0]     ag_bank,
  input  logic [AW-1:0]  ag_row,
  input  logic           rd_go,
  output logic           busy,
  output logic [FW-1:0]  fill
);

  localparam int DEPTH = 1 << AW;
  localparam logic [FW-1:0] NB3  = FW'(3);
  localparam logic [FW-1:0] NB4  = FW'(4);
  localparam logic [FW-1:0] CAP3 = FW'(3 * DEPTH);
  localparam logic [FW-1:0] CAP4 = FW'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    k;
  logic [AW-1:0] rd_row;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] mem [4][DEPTH];

  logic [FW-1:0] nb;
  logic [FW-1:0] cap;
  logic [1:0]    last_k;
  logic          sw;
  logic          accept;
  logic          start;
  logic          row_done;
  logic          bad_bank;

  assign nb     = ag_mode ? NB3 : NB4;
  assign cap    = ag_mode ? CAP3 : CAP4;
  assign last_k = ag_mode ? 2'd2 : 2'd3;

  // A layout change is only safe with nothing stored and no row in flight
  assign sw = r & (state == IDLE) & (fill == '0) & (mode != ag_mode);

  assign strm.in_ready = r & ~sw & (fill < cap);
  assign accept        = strm.in_valid & strm.in_ready;
  assign ag_en         = accept;
  assign ag_r          = ~r | sw;
  assign bad_bank      = ag_mode & (ag_bank == 2'd3);

  assign start    = (state == IDLE) & rd_go & (fill >= nb) & ~sw;
  assign row_done = (state == HOLD) & strm.out_ready & strm.out_last;
  assign busy     = (state != IDLE);

  assign strm.out_data = strm.out_valid ? ram_q : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   state_next = HOLD;
      HOLD:    if (strm.out_ready) state_next = strm.out_last ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!r) state <= IDLE;
    else    state <= state_next;
  end

  // Sample RAM is never reset; its read port only moves on ISSUE cycles
  always_ff @(posedge clk) begin
    if (accept && !bad_bank) mem[ag_bank][ag_row] <= strm.in_data;
    if (state == ISSUE)      ram_q <= mem[k][rd_row];
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      ag_mode        <= mode;
      fill           <= '0;
      rd_row         <= '0;
      k              <= '0;
      strm.out_valid <= 1'b0;
      strm.out_last  <= 1'b0;
      strm.out_bank  <= '0;
    end else begin
      if (sw) begin
        ag_mode <= mode;
        rd_row  <= '0;
      end
      fill <= fill + {{(FW-1){1'b0}}, accept} - (row_done ? nb : '0);
      if (start) k <= '0;
      case (state)
        ISSUE: begin
          strm.out_valid <= 1'b1;
          strm.out_bank  <= k;
          strm.out_last  <= (k == last_k);
        end
        HOLD: begin
          if (strm.out_ready) begin
            strm.out_valid <= 1'b0;
            strm.out_last  <= 1'b0;
            if (strm.out_last) rd_row <= rd_row + AW'(1);
            else               k      <= k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_input_buf.sv
// Self-checking bench for fir_input_buf: directed vector table, corner-case
// sequences and a randomized run checked against a FIFO-style reference model.
module tb_fir_input_buf;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int FW = 13;

  logic          clk = 1'b0;
  logic          r;
  logic          mode;
  logic          rd_go;
  logic          ag_mode;
  logic          ag_en;
  logic          ag_r;
  logic [1:0]    ag_bank;
  logic [AW-1:0] ag_row;
  logic          busy;
  logic [FW-1:0] fill;

  int tests = 0;
  int fails = 0;

  fir_input_buf_if #(.DW(DW)) bus ();

  fir_input_buf #(.DW(DW), .AW(AW), .FW(FW)) dut (
    .clk(clk), .r(r), .mode(mode), .strm(bus),
    .ag_mode(ag_mode), .ag_en(ag_en), .ag_r(ag_r),
    .ag_bank(ag_bank), .ag_row(ag_row),
    .rd_go(rd_go), .busy(busy), .fill(fill)
  );

  always #5 clk = ~clk;

  // Stand-in address generator: rotates banks 0..NB-1, bumping the row on wrap
  always @(posedge clk) begin
    if (ag_r) begin
      ag_bank <= 2'd0;
      ag_row  <= '0;
    end else if (ag_en) begin
      if (ag_bank == (ag_mode ? 2'd2 : 2'd3)) begin
        ag_bank <= 2'd0;
        ag_row  <= ag_row + 1'b1;
      end else begin
        ag_bank <= ag_bank + 2'd1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Reference model: the buffer behaves as a FIFO of samples drained NB at a time
  logic [DW-1:0] q[$];
  int            m_fill = 0;
  logic          m_mode = 1'b0;
  bit            m_busy = 0;
  int            m_k = 0;
  bit            seen_reset = 0;
  bit            prev_hold = 0;
  logic [DW-1:0] prev_data;
  logic [1:0]    prev_bank;

  int   nb_m, cap_m;
  bit   sw_m, rdy_m, acc_m, start_m, hs_m;

  always @(negedge clk) begin
    nb_m    = m_mode ? 3 : 4;
    cap_m   = nb_m * (1 << AW);
    sw_m    = r && !m_busy && m_fill == 0 && mode != m_mode;
    rdy_m   = r && !sw_m && m_fill < cap_m;
    acc_m   = bus.in_valid && rdy_m;
    start_m = r && !m_busy && rd_go && m_fill >= nb_m && !sw_m;
    hs_m    = r && m_busy && bus.out_valid && bus.out_ready;
    if (seen_reset) begin
      checkOutput("fill", fill, m_fill);
      checkOutput("in_ready", bus.in_ready, rdy_m);
      checkOutput("busy", busy, m_busy);
      checkOutput("ag_r", ag_r, (!r || sw_m));
      checkOutput("ag_en", ag_en, acc_m);
      checkOutput("ag_mode", ag_mode, m_mode);
      if (!m_busy) checkOutput("valid_idle", bus.out_valid, 1'b0);
      if (prev_hold) begin
        checkOutput("hold_valid", bus.out_valid, 1'b1);
        checkOutput("hold_data", bus.out_data, prev_data);
        checkOutput("hold_bank", bus.out_bank, prev_bank);
      end
      if (hs_m) begin
        if (q.size() == 0) checkOutput("word_avail", q.size(), 1);
        else               checkOutput("word_data", bus.out_data, q[0]);
        checkOutput("word_bank", bus.out_bank, m_k);
        checkOutput("word_last", bus.out_last, (m_k == nb_m - 1));
      end
    end
    prev_hold = r && bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
    prev_bank = bus.out_bank;
    if (!r) begin
      m_fill = 0; m_mode = mode; m_busy = 0; m_k = 0;
      q.delete();
      seen_reset = 1;
    end else begin
      if (hs_m) begin
        if (q.size() > 0) void'(q.pop_front());
        if (m_k == nb_m - 1) begin
          m_busy = 0; m_k = 0; m_fill -= nb_m;
        end else begin
          m_k++;
        end
      end
      if (acc_m) begin
        q.push_back(bus.in_data);
        m_fill++;
      end
      if (start_m) begin
        m_busy = 1; m_k = 0;
      end
      if (sw_m) m_mode = mode;
    end
  end

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        go;
    logic        ordy;
    int          e_fill;
    logic        e_busy;
    logic        e_agen;
    logic        e_ov;
    logic [1:0]  e_bank;
    logic        e_last;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic addVec(input logic iv, input logic [15:0] id, input logic go, input logic ordy,
                        input int e_fill, input logic e_busy, input logic e_agen, input logic e_ov,
                        input logic [1:0] e_bank, input logic e_last, input logic [15:0] e_data);
    vec_t v;
    v.iv = iv; v.id = id; v.go = go; v.ordy = ordy;
    v.e_fill = e_fill; v.e_busy = e_busy; v.e_agen = e_agen; v.e_ov = e_ov;
    v.e_bank = e_bank; v.e_last = e_last; v.e_data = e_data;
    tbl.push_back(v);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    stepCycle();
    bus.in_valid  = v.iv;
    bus.in_data   = v.id;
    rd_go         = v.go;
    bus.out_ready = v.ordy;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    @(negedge clk);
    checkOutput($sformatf("vec%0d_fill", idx), fill, v.e_fill);
    checkOutput($sformatf("vec%0d_busy", idx), busy, v.e_busy);
    checkOutput($sformatf("vec%0d_ag_en", idx), ag_en, v.e_agen);
    checkOutput($sformatf("vec%0d_valid", idx), bus.out_valid, v.e_ov);
    if (v.e_ov) begin
      checkOutput($sformatf("vec%0d_bank", idx), bus.out_bank, v.e_bank);
      checkOutput($sformatf("vec%0d_last", idx), bus.out_last, v.e_last);
      checkOutput($sformatf("vec%0d_data", idx), bus.out_data, v.e_data);
    end
  endtask

  task automatic setIdle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    rd_go         = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic resetDut(input logic m);
    stepCycle();
    r = 1'b0;
    mode = m;
    setIdle();
    repeat (2) stepCycle();
    r = 1'b1;
  endtask

  task automatic writeN(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      stepCycle();
      bus.in_valid = 1'b1;
      bus.in_data  = base + 16'(i);
    end
    stepCycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic readRow(output logic [1:0] lb);
    bit done;
    done = 0;
    lb   = 2'd0;
    stepCycle();
    rd_go = 1'b1;
    bus.out_ready = 1'b1;
    stepCycle();
    rd_go = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.out_valid && bus.out_last) lb = bus.out_bank;
      stepCycle();
      if (!busy) done = 1;
    end
    checkOutput("read_done", done, 1'b1);
  endtask

  task automatic waitValid(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.out_valid) got = 1;
      else               stepCycle();
    end
    checkOutput(name, got, 1'b1);
  endtask

  logic [1:0]    lb;
  logic [DW-1:0] held_data;
  logic [1:0]    held_bank;
  bit            found;

  initial begin
    r = 1'b0;
    mode = 1'b1;
    setIdle();

    // Directed table: six writes then one 3-bank row in mode 1
    addVec(1, 16'h11, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    addVec(1, 16'h12, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    addVec(1, 16'h13, 0, 1, 2, 0, 1, 0, 0, 0, 0);
    addVec(1, 16'h14, 0, 1, 3, 0, 1, 0, 0, 0, 0);
    addVec(1, 16'h15, 0, 1, 4, 0, 1, 0, 0, 0, 0);
    addVec(1, 16'h16, 0, 1, 5, 0, 1, 0, 0, 0, 0);
    addVec(0, 16'h00, 1, 1, 6, 0, 0, 0, 0, 0, 0);
    addVec(0, 16'h00, 0, 1, 6, 1, 0, 0, 0, 0, 0);
    addVec(0, 16'h00, 0, 1, 6, 1, 0, 1, 0, 0, 16'h11);
    addVec(0, 16'h00, 0, 1, 6, 1, 0, 0, 0, 0, 0);
    addVec(0, 16'h00, 0, 1, 6, 1, 0, 1, 1, 0, 16'h12);
    addVec(0, 16'h00, 0, 1, 6, 1, 0, 0, 0, 0, 0);
    addVec(0, 16'h00, 0, 1, 6, 1, 0, 1, 2, 1, 16'h13);
    addVec(0, 16'h00, 0, 1, 3, 0, 0, 0, 0, 0, 0);

    resetDut(1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkVector(i, tbl[i]);
    end
    setIdle();

    // Fill to capacity in mode 1, then free one row
    resetDut(1'b1);
    writeN(3072, 16'h1000);
    @(negedge clk);
    checkOutput("cap_fill", fill, 3072);
    checkOutput("cap_ready", bus.in_ready, 1'b0);
    writeN(1, 16'hdead);
    @(negedge clk);
    checkOutput("cap_refused", fill, 3072);
    readRow(lb);
    @(negedge clk);
    checkOutput("cap_after_read", fill, 3069);
    checkOutput("cap_ready_again", bus.in_ready, 1'b1);

    // Write on the same edge as the row-completing handshake
    stepCycle();
    rd_go = 1'b1;
    bus.out_ready = 1'b1;
    stepCycle();
    rd_go = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.out_valid && bus.out_last) begin
        found = 1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hbeef;
      end else begin
        stepCycle();
      end
    end
    checkOutput("sim_last_seen", found, 1'b1);
    stepCycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("sim_fill", fill, 3067);
    setIdle();

    // rd_go with too few samples is ignored
    resetDut(1'b1);
    writeN(2, 16'h0200);
    stepCycle();
    rd_go = 1'b1;
    stepCycle();
    rd_go = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("short_busy", busy, 1'b0);
      checkOutput("short_valid", bus.out_valid, 1'b0);
    end

    // Backpressure in HOLD, with a stray rd_go while busy
    writeN(4, 16'h0300);
    stepCycle();
    rd_go = 1'b1;
    stepCycle();
    rd_go = 1'b0;
    waitValid("bp_first_valid");
    held_data = bus.out_data;
    held_bank = bus.out_bank;
    checkOutput("bp_first_data", held_data, 16'h0200);
    for (int i = 0; i < 5; i++) begin
      rd_go = (i == 2);
      @(negedge clk);
      checkOutput("bp_data", bus.out_data, held_data);
      checkOutput("bp_bank", bus.out_bank, held_bank);
      checkOutput("bp_fill", fill, 6);
      stepCycle();
    end
    rd_go = 1'b0;
    bus.out_ready = 1'b1;
    stepCycle();
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_issue_gap", bus.out_valid, 1'b0);
    @(negedge clk);
    checkOutput("bp_next_valid", bus.out_valid, 1'b1);
    checkOutput("bp_next_bank", bus.out_bank, 2'd1);
    checkOutput("bp_next_data", bus.out_data, 16'h0201);
    stepCycle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) stepCycle();
    bus.out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("stray_go_busy", busy, 1'b0);
      checkOutput("stray_go_fill", fill, 3);
    end

    // Mode switch 1->0 on an empty buffer, then 4-word rows
    resetDut(1'b1);
    stepCycle();
    mode = 1'b0;
    @(negedge clk);
    checkOutput("sw_ag_r", ag_r, 1'b1);
    checkOutput("sw_in_ready", bus.in_ready, 1'b0);
    stepCycle();
    @(negedge clk);
    checkOutput("sw_done_ag_r", ag_r, 1'b0);
    checkOutput("sw_done_ready", bus.in_ready, 1'b1);
    checkOutput("sw_done_mode", ag_mode, 1'b0);
    writeN(8, 16'h0400);
    readRow(lb);
    checkOutput("m0_last_bank_a", lb, 2'd3);
    readRow(lb);
    checkOutput("m0_last_bank_b", lb, 2'd3);

    // Switch request with fill=4 waits for the buffer to drain
    writeN(4, 16'h0500);
    stepCycle();
    mode = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("defer_ag_r", ag_r, 1'b0);
      checkOutput("defer_mode", ag_mode, 1'b0);
    end
    readRow(lb);
    @(negedge clk);
    checkOutput("defer_sw_ag_r", ag_r, 1'b1);
    stepCycle();
    @(negedge clk);
    checkOutput("defer_new_mode", ag_mode, 1'b1);

    // Reset while holding bank 1 aborts the row
    writeN(3, 16'h0600);
    stepCycle();
    rd_go = 1'b1;
    stepCycle();
    rd_go = 1'b0;
    waitValid("abort_v0");
    bus.out_ready = 1'b1;
    stepCycle();
    bus.out_ready = 1'b0;
    waitValid("abort_v1");
    checkOutput("abort_bank", bus.out_bank, 2'd1);
    r = 1'b0;
    @(negedge clk);
    checkOutput("abort_ag_r", ag_r, 1'b1);
    stepCycle();
    @(negedge clk);
    checkOutput("abort_valid", bus.out_valid, 1'b0);
    checkOutput("abort_fill", fill, 0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_ag_r_held", ag_r, 1'b1);
    stepCycle();
    r = 1'b1;

    // Row pointer wrap: more than 2^AW rows through a 3-bank layout
    resetDut(1'b1);
    for (int row = 0; row < 1030; row++) begin
      writeN(3, 16'(row * 3));
      readRow(lb);
    end
    @(negedge clk);
    checkOutput("wrap_fill", fill, 0);

    // Randomized traffic against the reference model
    resetDut(1'(($urandom) % 2));
    for (int i = 0; i < 4000; i++) begin
      stepCycle();
      bus.in_valid  = 1'($urandom % 2);
      bus.in_data   = 16'($urandom);
      rd_go         = ($urandom % 4) == 0;
      bus.out_ready = ($urandom % 4) != 0;
      if ($urandom % 200 == 0) mode = ~mode;
      r = ($urandom % 600) != 0;
    end
    stepCycle();
    r = 1'b1;
    setIdle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && busy; i++) stepCycle();
    @(negedge clk);
    checkOutput("rand_drained", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
